// File: rtl/dma_pkg.sv
// ---------------------------------------------------------------------------
// dma_pkg
// Shared definitions for the 8237A-style DMA transfer sequencer:
//   - dma_state_e : sequencer states (SI idle, S0 hold request, S1..S4 transfer
//                   cycle, SW wait state inserted between S3 and S4)
//   - transfer-mode codes (chanMode[7:6]) and transfer-type codes
//     (chanMode[3:2])
//   - svc_ends()  : decides at S4 whether the current service is finished
// ---------------------------------------------------------------------------
package dma_pkg;

  typedef enum logic [2:0] {
    SI = 3'd0,
    S0 = 3'd1,
    S1 = 3'd2,
    S2 = 3'd3,
    S3 = 3'd4,
    SW = 3'd5,
    S4 = 3'd6
  } dma_state_e;

  // Transfer mode, chanMode[7:6]
  localparam logic [1:0] DEMAND  = 2'b00;
  localparam logic [1:0] SINGLE  = 2'b01;
  localparam logic [1:0] BLOCK   = 2'b10;
  localparam logic [1:0] CASCADE = 2'b11;

  // Transfer type, chanMode[3:2]
  localparam logic [1:0] VERIFY = 2'b00;
  localparam logic [1:0] WRITE  = 2'b01;  // I/O -> memory
  localparam logic [1:0] READ   = 2'b10;  // memory -> I/O

  // End-of-service decision taken in S4.
  //   end_cond   : terminal count or external EOP seen during this transfer
  //   req_active : DREQ of the serviced channel is still asserted
  function automatic logic svc_ends(input logic [1:0] mode,
                                    input logic       end_cond,
                                    input logic       req_active);
    logic result;
    case (mode)
      SINGLE:  result = 1'b1;
      BLOCK:   result = end_cond;
      DEMAND:  result = end_cond | ~req_active;
      default: result = 1'b1;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/dma_timing_ctrl_if.sv
// ---------------------------------------------------------------------------
// dma_timing_ctrl_if
// Bundles every handshake / bus signal of the DMA transfer sequencer.
//   Inputs to the sequencer : grantValid, grantCh, chanReq, chanMode, HLDA,
//                             READY, EOP_N_IN, tcIn
//   Outputs of the sequencer: HRQ, AEN, ADSTB, dackOneHot, MEMR_N, MEMW_N,
//                             IOR_N, IOW_N, EOP_N_OUT, decCount, activeCh,
//                             svcDone
// Modports:
//   master : the sequencer itself
//   slave  : the surrounding logic (priority block, count block, bus pins)
// ---------------------------------------------------------------------------
interface dma_timing_ctrl_if;

  logic       grantValid;
  logic [1:0] grantCh;
  logic [3:0] chanReq;
  logic [7:0] chanMode;
  logic       HLDA;
  logic       READY;
  logic       EOP_N_IN;
  logic       tcIn;

  logic       HRQ;
  logic       AEN;
  logic       ADSTB;
  logic [3:0] dackOneHot;
  logic       MEMR_N;
  logic       MEMW_N;
  logic       IOR_N;
  logic       IOW_N;
  logic       EOP_N_OUT;
  logic       decCount;
  logic [1:0] activeCh;
  logic       svcDone;

  modport master (
    input  grantValid, grantCh, chanReq, chanMode, HLDA, READY, EOP_N_IN, tcIn,
    output HRQ, AEN, ADSTB, dackOneHot, MEMR_N, MEMW_N, IOR_N, IOW_N,
           EOP_N_OUT, decCount, activeCh, svcDone
  );

  modport slave (
    output grantValid, grantCh, chanReq, chanMode, HLDA, READY, EOP_N_IN, tcIn,
    input  HRQ, AEN, ADSTB, dackOneHot, MEMR_N, MEMW_N, IOR_N, IOW_N,
           EOP_N_OUT, decCount, activeCh, svcDone
  );

endinterface

// File: rtl/dma_strobe_gen.sv
// ---------------------------------------------------------------------------
// dma_strobe_gen
// Purely combinational decode of the sequencer state and transfer type into
// the four active-low bus strobes.
//   state_i     : current sequencer state
//   xfer_type_i : transfer type (VERIFY / WRITE / READ)
//   memr_n_o, memw_n_o, ior_n_o, iow_n_o : active-low bus strobes
// The read strobe covers S2, S3 and any wait states. The write strobe covers
// S3 and wait states, and additionally S2 when EXT_WRITE = 1. Verify
// transfers (and the reserved type code) never drive a strobe.
// ---------------------------------------------------------------------------
module dma_strobe_gen
  import dma_pkg::*;
#(
  parameter bit EXT_WRITE = 1'b0
) (
  input  dma_state_e state_i,
  input  logic [1:0] xfer_type_i,
  output logic       memr_n_o,
  output logic       memw_n_o,
  output logic       ior_n_o,
  output logic       iow_n_o
);

  logic rd_phase;
  logic wr_phase;

  assign rd_phase = (state_i == S2) || (state_i == S3) || (state_i == SW);
  assign wr_phase = (state_i == S3) || (state_i == SW) ||
                    (EXT_WRITE && (state_i == S2));

  // Write-to-memory reads the I/O device and writes memory;
  // read-from-memory reads memory and writes the I/O device.
  assign ior_n_o  = ~((xfer_type_i == WRITE) && rd_phase);
  assign memw_n_o = ~((xfer_type_i == WRITE) && wr_phase);
  assign memr_n_o = ~((xfer_type_i == READ)  && rd_phase);
  assign iow_n_o  = ~((xfer_type_i == READ)  && wr_phase);

endmodule

// File: rtl/dma_timing_ctrl.sv
// ---------------------------------------------------------------------------
// dma_timing_ctrl
// Transfer sequencer of the 8237A-style DMA controller. Takes the winning
// channel from the priority block, runs the HRQ/HLDA handshake, steps through
// the S0..S4 transfer timing (with SW wait states while READY is low), and
// produces DACK, AEN, ADSTB, the bus strobes, the count-decrement pulse and
// the end-of-service pulse.
// Ports:
//   CLK   : system clock
//   RESET : synchronous, active-high reset
//   bus   : dma_timing_ctrl_if.master, all handshake / bus signals
// Outputs are decoded from the registered state; decCount, svcDone and
// EOP_N_OUT additionally look at the current-cycle inputs of S4 (or S1 for
// cascade), so they line up with the cycle in which the decision is made.
// ---------------------------------------------------------------------------
module dma_timing_ctrl
  import dma_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter bit EXT_WRITE = 1'b0
) (
  input  logic                      CLK,
  input  logic                      RESET,
  dma_timing_ctrl_if.master         bus
);

  dma_state_e state_q, state_d;
  logic [1:0] ch_q, ch_d;
  logic [1:0] mode_q, mode_d;        // transfer mode of the serviced channel
  logic [1:0] type_q, type_d;        // transfer type of the serviced channel
  logic       first_q, first_d;      // next S1 is the first of this service
  logic       eop_seen_q, eop_seen_d;

  logic       req_active;
  logic       is_cascade;
  logic       in_xfer;
  logic       eop_now;
  logic       end_cond;
  logic       svc_end;
  logic       cascade_end;

  // Autoinit / direction bits are consumed by the register block.
  logic       unused_mode_bits;
  assign unused_mode_bits = ^{bus.chanMode[5:4], bus.chanMode[1:0]};

  assign req_active = bus.chanReq[ch_q];
  assign is_cascade = (mode_q == CASCADE);
  assign in_xfer    = (state_q == S1) || (state_q == S2) || (state_q == S3) ||
                      (state_q == SW) || (state_q == S4);

  // External EOP counts only while a transfer is on the bus (S2..S4).
  assign eop_now  = ~bus.EOP_N_IN &&
                    ((state_q == S2) || (state_q == S3) ||
                     (state_q == SW) || (state_q == S4));
  assign end_cond = bus.tcIn | eop_seen_q | eop_now;
  assign svc_end  = svc_ends(mode_q, end_cond, req_active);
  assign cascade_end = (state_q == S1) && is_cascade && ~req_active;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    mode_d     = mode_q;
    type_d     = type_q;
    first_d    = first_q;
    eop_seen_d = eop_seen_q;

    case (state_q)
      SI: begin
        if (bus.grantValid) begin
          ch_d       = bus.grantCh;
          mode_d     = bus.chanMode[7:6];
          type_d     = bus.chanMode[3:2];
          first_d    = 1'b1;
          eop_seen_d = 1'b0;
          state_d    = S0;
        end
      end

      S0: begin
        // HLDA wins over a simultaneous request drop: the bus is ours.
        if (bus.HLDA) begin
          state_d = S1;
        end else if (!req_active) begin
          state_d = SI;
        end
      end

      S1: begin
        if (is_cascade) begin
          // The slave controller owns the bus; we only hold DACK.
          if (!req_active) begin
            state_d = SI;
          end
        end else begin
          first_d = 1'b0;
          state_d = S2;
        end
      end

      S2: begin
        eop_seen_d = eop_seen_q | eop_now;
        state_d    = S3;
      end

      S3: begin
        eop_seen_d = eop_seen_q | eop_now;
        state_d    = bus.READY ? S4 : SW;
      end

      SW: begin
        eop_seen_d = eop_seen_q | eop_now;
        if (bus.READY) begin
          state_d = S4;
        end
      end

      S4: begin
        eop_seen_d = 1'b0;
        state_d    = svc_end ? SI : S1;
      end

      default: begin
        state_d = SI;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= SI;
      ch_q       <= 2'd0;
      mode_q     <= DEMAND;
      type_q     <= VERIFY;
      first_q    <= 1'b0;
      eop_seen_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      mode_q     <= mode_d;
      type_q     <= type_d;
      first_q    <= first_d;
      eop_seen_q <= eop_seen_d;
    end
  end

  // -------------------------------------------------------------------------
  // Output decode
  // -------------------------------------------------------------------------
  assign bus.HRQ      = (state_q != SI);
  assign bus.AEN      = in_xfer && !is_cascade;
  assign bus.ADSTB    = (state_q == S1) && first_q && !is_cascade;
  assign bus.activeCh = ch_q;

  // Pulses are suppressed in a reset cycle so an aborted transfer never
  // updates the counters or clears a request.
  assign bus.decCount  = (state_q == S4) && !RESET;
  assign bus.svcDone   = !RESET && (((state_q == S4) && svc_end) || cascade_end);
  assign bus.EOP_N_OUT = ~((state_q == S4) && bus.tcIn);

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_dack
      assign bus.dackOneHot[gi] = in_xfer && (ch_q == 2'(gi));
    end
  endgenerate

  dma_strobe_gen #(
    .EXT_WRITE (EXT_WRITE)
  ) u_strobe_gen (
    .state_i     (is_cascade ? SI : state_q),
    .xfer_type_i (type_q),
    .memr_n_o    (bus.MEMR_N),
    .memw_n_o    (bus.MEMW_N),
    .ior_n_o     (bus.IOR_N),
    .iow_n_o     (bus.IOW_N)
  );

endmodule

// File: tb/tb_dma_timing_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dma_timing_ctrl
// Directed, table-driven bench for dma_timing_ctrl. Each vector is one clock
// cycle: inputs are driven on the falling edge and the outputs are compared
// 1 ns later against a hand-computed packed word
//   {HRQ, AEN, ADSTB, dackOneHot[3:0], MEMR_N, MEMW_N, IOR_N, IOW_N,
//    EOP_N_OUT, decCount, svcDone, activeCh[1:0]}
// ---------------------------------------------------------------------------
module tb_dma_timing_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dma_timing_ctrl_if bus_if ();

  dma_timing_ctrl #(
    .NUM_CH    (4),
    .EXT_WRITE (1'b0)
  ) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus_if.master)
  );

  typedef struct packed {
    logic        rst;
    logic        gv;
    logic [1:0]  gch;
    logic [3:0]  req;
    logic [7:0]  mode;
    logic        hlda;
    logic        rdy;
    logic        eopn;
    logic        tc;
    logic [15:0] exp;
  } vec_t;

  vec_t  tbl[$];
  string tags[$];
  int    vec_count = 0;
  int    err_count = 0;

  // Strobe nibbles {MEMR_N, MEMW_N, IOR_N, IOW_N}
  localparam logic [3:0] NS    = 4'b1111;
  localparam logic [3:0] MR    = 4'b0111;
  localparam logic [3:0] MR_IW = 4'b0110;
  localparam logic [3:0] IR    = 4'b1101;
  localparam logic [3:0] IR_MW = 4'b1001;

  // Mode bytes: [7:6] mode, [3:2] type
  localparam logic [7:0] M_SGL_RD = 8'h48;
  localparam logic [7:0] M_BLK_WR = 8'h84;
  localparam logic [7:0] M_DMD_RD = 8'h08;
  localparam logic [7:0] M_CAS    = 8'hC0;
  localparam logic [7:0] M_BLK_RD = 8'h88;

  function automatic logic [15:0] ex(input logic hrq, input logic aen,
                                     input logic adstb, input logic [3:0] dack,
                                     input logic [3:0] strb, input logic eopn,
                                     input logic dec, input logic done,
                                     input logic [1:0] ch);
    return {hrq, aen, adstb, dack, strb, eopn, dec, done, ch};
  endfunction

  function automatic logic [15:0] idle(input logic [1:0] ch);
    return ex(1'b0, 1'b0, 1'b0, 4'b0000, NS, 1'b1, 1'b0, 1'b0, ch);
  endfunction

  function automatic logic [15:0] hold(input logic [1:0] ch);
    return ex(1'b1, 1'b0, 1'b0, 4'b0000, NS, 1'b1, 1'b0, 1'b0, ch);
  endfunction

  function automatic logic [15:0] bz(input logic adstb, input logic [3:0] dack,
                                     input logic [3:0] strb, input logic dec,
                                     input logic done, input logic eopn,
                                     input logic [1:0] ch);
    return ex(1'b1, 1'b1, adstb, dack, strb, eopn, dec, done, ch);
  endfunction

  function automatic vec_t mk(input logic r, input logic gv, input logic [1:0] gch,
                              input logic [3:0] req, input logic [7:0] mode,
                              input logic hlda, input logic rdy, input logic eopn,
                              input logic tc, input logic [15:0] e);
    vec_t v;
    v.rst = r; v.gv = gv; v.gch = gch; v.req = req; v.mode = mode;
    v.hlda = hlda; v.rdy = rdy; v.eopn = eopn; v.tc = tc; v.exp = e;
    return v;
  endfunction

  task automatic add(input string t, input vec_t v);
    tbl.push_back(v);
    tags.push_back(t);
  endtask

  task automatic apply(input string t, input vec_t v);
    logic [15:0] act;
    @(negedge clk);
    rst                 = v.rst;
    bus_if.grantValid   = v.gv;
    bus_if.grantCh      = v.gch;
    bus_if.chanReq      = v.req;
    bus_if.chanMode     = v.mode;
    bus_if.HLDA         = v.hlda;
    bus_if.READY        = v.rdy;
    bus_if.EOP_N_IN     = v.eopn;
    bus_if.tcIn         = v.tc;
    #1;
    act = {bus_if.HRQ, bus_if.AEN, bus_if.ADSTB, bus_if.dackOneHot,
           bus_if.MEMR_N, bus_if.MEMW_N, bus_if.IOR_N, bus_if.IOW_N,
           bus_if.EOP_N_OUT, bus_if.decCount, bus_if.svcDone, bus_if.activeCh};
    vec_count++;
    if (act !== v.exp) begin
      err_count++;
      $display("FAIL %s vec %0d: got %h, expected %h", t, vec_count, act, v.exp);
    end else begin
      $display("vec %0d %s: out=%h ok", vec_count, t, act);
    end
  endtask

  initial begin
    logic [3:0] d;

    // ---------------- table fill ----------------
    add("reset", mk(0, 0, 0, 4'b0000, 8'h00, 0, 1, 1, 0, idle(0)));

    // Single read-from-mem, ch2, HLDA three cycles after HRQ
    d = 4'b0100;
    add("sgl_rd", mk(0, 1, 2, d, M_SGL_RD, 0, 1, 1, 0, idle(0)));
    for (int i = 0; i < 3; i++)
      add("sgl_rd", mk(0, 0, 0, d, M_SGL_RD, 0, 1, 1, 0, hold(2)));
    add("sgl_rd", mk(0, 0, 0, d, M_SGL_RD, 1, 1, 1, 0, hold(2)));
    add("sgl_rd", mk(0, 0, 0, d, M_SGL_RD, 1, 1, 1, 0, bz(1, d, NS,    0, 0, 1, 2)));
    add("sgl_rd", mk(0, 0, 0, d, M_SGL_RD, 1, 1, 1, 0, bz(0, d, MR,    0, 0, 1, 2)));
    add("sgl_rd", mk(0, 0, 0, d, M_SGL_RD, 1, 1, 1, 0, bz(0, d, MR_IW, 0, 0, 1, 2)));
    add("sgl_rd", mk(0, 0, 0, d, M_SGL_RD, 1, 1, 1, 0, bz(0, d, NS,    1, 1, 1, 2)));
    add("sgl_rd", mk(0, 0, 0, d, M_SGL_RD, 0, 1, 1, 0, idle(2)));

    // Block write-to-mem, ch0, TC on the third word
    d = 4'b0001;
    add("blk_wr", mk(0, 1, 0, d, M_BLK_WR, 0, 1, 1, 0, idle(2)));
    add("blk_wr", mk(0, 0, 0, d, M_BLK_WR, 1, 1, 1, 0, hold(0)));
    for (int k = 0; k < 3; k++) begin
      add("blk_wr", mk(0, 0, 0, d, M_BLK_WR, 1, 1, 1, 0, bz(k == 0, d, NS, 0, 0, 1, 0)));
      add("blk_wr", mk(0, 0, 0, d, M_BLK_WR, 1, 1, 1, 0, bz(0, d, IR,    0, 0, 1, 0)));
      add("blk_wr", mk(0, 0, 0, d, M_BLK_WR, 1, 1, 1, 0, bz(0, d, IR_MW, 0, 0, 1, 0)));
      add("blk_wr", mk(0, 0, 0, d, M_BLK_WR, 1, 1, 1, k == 2,
                       bz(0, d, NS, 1, k == 2, k != 2, 0)));
    end
    add("blk_wr", mk(0, 0, 0, d, M_BLK_WR, 0, 1, 1, 0, idle(0)));

    // Demand read, ch1, request drops in the second S4
    d = 4'b0010;
    add("dmd_rd", mk(0, 1, 1, d, M_DMD_RD, 0, 1, 1, 0, idle(0)));
    add("dmd_rd", mk(0, 0, 0, d, M_DMD_RD, 1, 1, 1, 0, hold(1)));
    for (int k = 0; k < 2; k++) begin
      add("dmd_rd", mk(0, 0, 0, d, M_DMD_RD, 1, 1, 1, 0, bz(k == 0, d, NS, 0, 0, 1, 1)));
      add("dmd_rd", mk(0, 0, 0, d, M_DMD_RD, 1, 1, 1, 0, bz(0, d, MR,    0, 0, 1, 1)));
      add("dmd_rd", mk(0, 0, 0, d, M_DMD_RD, 1, 1, 1, 0, bz(0, d, MR_IW, 0, 0, 1, 1)));
      add("dmd_rd", mk(0, 0, 0, (k == 1) ? 4'b0000 : d, M_DMD_RD, 1, 1, 1, 0,
                       bz(0, d, NS, 1, k == 1, 1, 1)));
    end
    add("dmd_rd", mk(0, 0, 0, 4'b0000, M_DMD_RD, 0, 1, 1, 0, idle(1)));

    // Request withdrawn in S0 before HLDA: back to idle, no pulse
    add("s0_drop", mk(0, 1, 3, 4'b1000, M_SGL_RD, 0, 1, 1, 0, idle(1)));
    add("s0_drop", mk(0, 0, 0, 4'b1000, M_SGL_RD, 0, 1, 1, 0, hold(3)));
    add("s0_drop", mk(0, 0, 0, 4'b0000, M_SGL_RD, 0, 1, 1, 0, hold(3)));
    add("s0_drop", mk(0, 0, 0, 4'b0000, M_SGL_RD, 0, 1, 1, 0, idle(3)));
    add("s0_drop", mk(0, 0, 0, 4'b0000, M_SGL_RD, 1, 1, 1, 0, idle(3)));

    // Cascade, ch2: DACK only, held while the request stays up
    d = 4'b0100;
    add("cascade", mk(0, 1, 2, d, M_CAS, 0, 1, 1, 0, idle(3)));
    add("cascade", mk(0, 0, 0, d, M_CAS, 1, 1, 1, 0, hold(2)));
    add("cascade", mk(0, 0, 0, d, M_CAS, 1, 1, 1, 0, ex(1, 0, 0, d, NS, 1, 0, 0, 2)));
    add("cascade", mk(0, 0, 0, d, M_CAS, 1, 1, 1, 0, ex(1, 0, 0, d, NS, 1, 0, 0, 2)));
    add("cascade", mk(0, 0, 0, 4'b0000, M_CAS, 1, 1, 1, 0, ex(1, 0, 0, d, NS, 1, 0, 1, 2)));
    add("cascade", mk(0, 0, 0, 4'b0000, M_CAS, 0, 1, 1, 0, idle(2)));

    // ---------------- reset and table replay ----------------
    rst = 1'b1;
    bus_if.grantValid = 1'b0; bus_if.grantCh = 2'd0; bus_if.chanReq = 4'd0;
    bus_if.chanMode = 8'h00; bus_if.HLDA = 1'b0; bus_if.READY = 1'b1;
    bus_if.EOP_N_IN = 1'b1; bus_if.tcIn = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < tbl.size(); i++)
      apply(tags[i], tbl[i]);

    // ---------------- READY low for three cycles ----------------
    d = 4'b0100;
    apply("wait", mk(0, 1, 2, d, M_SGL_RD, 0, 1, 1, 0, idle(2)));
    apply("wait", mk(0, 0, 0, d, M_SGL_RD, 1, 1, 1, 0, hold(2)));
    apply("wait", mk(0, 0, 0, d, M_SGL_RD, 1, 1, 1, 0, bz(1, d, NS,    0, 0, 1, 2)));
    apply("wait", mk(0, 0, 0, d, M_SGL_RD, 1, 1, 1, 0, bz(0, d, MR,    0, 0, 1, 2)));
    apply("wait", mk(0, 0, 0, d, M_SGL_RD, 1, 0, 1, 0, bz(0, d, MR_IW, 0, 0, 1, 2)));
    for (int i = 0; i < 3; i++)
      apply("wait_sw", mk(0, 0, 0, d, M_SGL_RD, 1, i == 2, 1, 0, bz(0, d, MR_IW, 0, 0, 1, 2)));
    apply("wait", mk(0, 0, 0, d, M_SGL_RD, 1, 1, 1, 0, bz(0, d, NS, 1, 1, 1, 2)));
    apply("wait", mk(0, 0, 0, d, M_SGL_RD, 0, 1, 1, 0, idle(2)));

    // ---------------- external EOP in S2 of the first block word ----------------
    d = 4'b1000;
    apply("eop", mk(0, 1, 3, d, M_BLK_RD, 0, 1, 1, 0, idle(2)));
    apply("eop", mk(0, 0, 0, d, M_BLK_RD, 1, 1, 1, 0, hold(3)));
    apply("eop", mk(0, 0, 0, d, M_BLK_RD, 1, 1, 1, 0, bz(1, d, NS,    0, 0, 1, 3)));
    apply("eop", mk(0, 0, 0, d, M_BLK_RD, 1, 1, 0, 0, bz(0, d, MR,    0, 0, 1, 3)));
    apply("eop", mk(0, 0, 0, d, M_BLK_RD, 1, 1, 1, 0, bz(0, d, MR_IW, 0, 0, 1, 3)));
    apply("eop", mk(0, 0, 0, d, M_BLK_RD, 1, 1, 1, 0, bz(0, d, NS,    1, 1, 1, 3)));
    apply("eop", mk(0, 0, 0, d, M_BLK_RD, 1, 1, 1, 0, idle(3)));
    apply("eop", mk(0, 0, 0, d, M_BLK_RD, 1, 1, 1, 0, idle(3)));

    // ---------------- RESET in a wait state, then a clean service ----------------
    d = 4'b0010;
    apply("rst_sw", mk(0, 1, 1, d, M_SGL_RD, 0, 1, 1, 0, idle(3)));
    apply("rst_sw", mk(0, 0, 0, d, M_SGL_RD, 1, 1, 1, 0, hold(1)));
    apply("rst_sw", mk(0, 0, 0, d, M_SGL_RD, 1, 1, 1, 0, bz(1, d, NS,    0, 0, 1, 1)));
    apply("rst_sw", mk(0, 0, 0, d, M_SGL_RD, 1, 1, 1, 0, bz(0, d, MR,    0, 0, 1, 1)));
    apply("rst_sw", mk(0, 0, 0, d, M_SGL_RD, 1, 0, 1, 0, bz(0, d, MR_IW, 0, 0, 1, 1)));
    apply("rst_sw", mk(0, 0, 0, d, M_SGL_RD, 1, 0, 1, 0, bz(0, d, MR_IW, 0, 0, 1, 1)));
    apply("rst_sw", mk(1, 0, 0, d, M_SGL_RD, 1, 1, 1, 1, bz(0, d, MR_IW, 0, 0, 1, 1)));
    apply("rst_post", mk(0, 0, 0, d, M_SGL_RD, 1, 1, 1, 0, idle(0)));
    apply("rst_post", mk(0, 1, 1, d, M_SGL_RD, 0, 1, 1, 0, idle(0)));
    apply("rst_post", mk(0, 0, 0, d, M_SGL_RD, 1, 1, 1, 0, hold(1)));
    apply("rst_post", mk(0, 0, 0, d, M_SGL_RD, 1, 1, 1, 0, bz(1, d, NS,    0, 0, 1, 1)));
    apply("rst_post", mk(0, 0, 0, d, M_SGL_RD, 1, 1, 1, 0, bz(0, d, MR,    0, 0, 1, 1)));
    apply("rst_post", mk(0, 0, 0, d, M_SGL_RD, 1, 1, 1, 0, bz(0, d, MR_IW, 0, 0, 1, 1)));
    apply("rst_post", mk(0, 0, 0, d, M_SGL_RD, 1, 1, 1, 0, bz(0, d, NS,    1, 1, 1, 1)));
    apply("rst_post", mk(0, 0, 0, d, M_SGL_RD, 0, 1, 1, 0, idle(1)));

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
